mux16to1_pipe: RTL and testbench
================================

Name: mux16to1_pipe

Overview:
- Registered 16:1 bit-select multiplexer: picks one element of a packed input vector by binary select and presents it on a registered output one clock later.
- Generic datapath selector for control/status fan-in. Sits between a wide status bus and a single-bit (or narrow) consumer that needs a glitch-free, clock-aligned output.
- Includes a valid qualifier and an out-of-range select flag for non-power-of-two configurations.

Parameters:
- N_IN, 16, number of selectable input elements (2..256).
- DATA_W, 1, width of each element in bits.
- SEL_W, 4, select width; must satisfy 2**SEL_W >= N_IN (elaboration-time check, fatal on violation).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in  input  N_IN*DATA_W  packed inputs; element k = in[k*DATA_W +: DATA_W].
- sel  input  SEL_W  binary index of element to forward.
- in_valid  input  1  qualifies in/sel this cycle.
- out  output  DATA_W  registered selected element.
- out_valid  output  1  registered copy of in_valid.
- sel_err  output  1  registered flag: sel >= N_IN while in_valid=1.

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous-to-clk deassert handled by upstream reset synchronizer): out=0, out_valid=0, sel_err=0 immediately, held while rst_n=0.
- Latency exactly 1 cycle: at rising clk with in_valid=1, out <= in[sel*DATA_W +: DATA_W], out_valid <= 1, sel_err <= (sel >= N_IN).
- in_valid=0 at rising edge: out holds previous value; out_valid <= 0; sel_err <= 0.
- Out-of-range sel (sel >= N_IN, only possible when N_IN < 2**SEL_W) with in_valid=1: out <= 0, sel_err <= 1, out_valid <= 1.
- No X propagation from sel: unknown sel drives the all-zero default path in the combinational core.
- Back-to-back: a new sel/in every cycle gives a new out every cycle, no bubbles, no backpressure.
- Reset asserted mid-stream: outputs clear immediately; first valid sample after rst_n rises is captured at the first rising edge with in_valid=1.
- Combinational path from in/sel into the output register only; no combinational path from any input to any output.

Decomposition:
- Package mux_pkg: default constants MUX_N_IN=16, MUX_DATA_W=1, MUX_SEL_W=4, and a function clog2_min(n) used for the SEL_W sanity check.
- One sub-module: mux_core (purely combinational N_IN:1 selector with out-of-range flag, same parameters). mux16to1_pipe instantiates mux_core and adds the output/valid/error registers and the elaboration check.

Test Plan:
- Reset: hold rst_n=0 with in=16'h5555, sel=0, in_valid=1 -> out=0, out_valid=0, sel_err=0 throughout; release and on the next edge out=1, out_valid=1.
- Full sweep: in=16'h5555, in_valid=1, sel=0..15 one per cycle -> out one cycle later = 1 for even sel, 0 for odd sel; out_valid=1 continuously; sel_err=0.
- One-hot walk: in=16'h0001<<k with sel=k for k=0..15, then sel=(k+1)%16 -> out=1 then 0 respectively; confirms every index maps to its own bit.
- Valid gating: after out=1 (in=16'hFFFF, sel=3), drive in_valid=0 with in=16'h0000 -> out stays 1, out_valid=0.
- Async reset mid-stream: assert rst_n=0 between clock edges while out=1 -> out/out_valid drop to 0 before the next edge; deassert and resume the sweep correctly.
- Out-of-range (N_IN=12, SEL_W=4): in=12'hFFF, sel=13, in_valid=1 -> out=0, sel_err=1, out_valid=1 next cycle; sel=11 -> out=1, sel_err=0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared defaults and the select-width helper for the registered bit-select mux.
package mux_pkg;

  localparam int MUX_N_IN   = 16;
  localparam int MUX_DATA_W = 1;
  localparam int MUX_SEL_W  = 4;

  // Smallest select width that can address n elements (at least 1 bit).
  function automatic int clog2_min(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mux_core.sv
// Combinational N_IN:1 element selector with an out-of-range select flag.
module mux_core
  import mux_pkg::*;
#(
  parameter int N_IN   = MUX_N_IN,
  parameter int DATA_W = MUX_DATA_W,
  parameter int SEL_W  = MUX_SEL_W
) (
  input  logic [N_IN*DATA_W-1:0] in,
  input  logic [SEL_W-1:0]       sel,
  output logic [DATA_W-1:0]      data,
  output logic                   oor
);

  // Out-of-range selects exist only when the select space exceeds N_IN.
  localparam bit HAS_OOR = (N_IN < (1 << SEL_W));

  // Match-per-index form: an unknown or out-of-range sel matches nothing and
  // leaves data on its all-zero default.
  always_comb begin
    data = '0;
    oor  = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) data = in[k*DATA_W +: DATA_W];
    end
    if (HAS_OOR && (sel >= SEL_W'(N_IN))) oor = 1'b1;
  end

endmodule

// File: rtl/mux16to1_pipe.sv
// Registered bit-select mux: one-cycle latency, valid qualifier, out-of-range flag.
module mux16to1_pipe
  import mux_pkg::*;
#(
  parameter int N_IN   = MUX_N_IN,
  parameter int DATA_W = MUX_DATA_W,
  parameter int SEL_W  = MUX_SEL_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN*DATA_W-1:0] in,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   in_valid,
  output logic [DATA_W-1:0]      out,
  output logic                   out_valid,
  output logic                   sel_err
);

  if (N_IN < 2 || N_IN > 256) begin : g_bad_n_in
    $fatal(1, "mux16to1_pipe: N_IN=%0d outside 2..256", N_IN);
  end
  if (SEL_W < clog2_min(N_IN)) begin : g_bad_sel_w
    $fatal(1, "mux16to1_pipe: SEL_W=%0d too narrow for N_IN=%0d", SEL_W, N_IN);
  end

  logic [DATA_W-1:0] core_data;
  logic              core_oor;

  mux_core #(
    .N_IN  (N_IN),
    .DATA_W(DATA_W),
    .SEL_W (SEL_W)
  ) u_core (
    .in  (in),
    .sel (sel),
    .data(core_data),
    .oor (core_oor)
  );

  // Valid-only stream, no ready: every cycle with in_valid=1 is accepted and
  // appears on out/out_valid one clock later; out holds when in_valid=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else if (in_valid) begin
      out       <= core_data;
      out_valid <= 1'b1;
      sel_err   <= core_oor;
    end else begin
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux16to1_pipe.sv
// Directed bench for mux16to1_pipe: default 16:1 instance plus a 12-input instance.
module tb_mux16to1_pipe;

  logic        clk;
  logic        rst_n;

  logic [15:0] in16;
  logic [3:0]  sel16;
  logic        valid16;
  logic        out16;
  logic        ovalid16;
  logic        err16;

  logic [11:0] in12;
  logic [3:0]  sel12;
  logic        valid12;
  logic        out12;
  logic        ovalid12;
  logic        err12;

  int n_checks;
  int n_fail;

  mux16to1_pipe u_dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in16),
    .sel      (sel16),
    .in_valid (valid16),
    .out      (out16),
    .out_valid(ovalid16),
    .sel_err  (err16)
  );

  mux16to1_pipe #(
    .N_IN  (12),
    .DATA_W(1),
    .SEL_W (4)
  ) u_dut12 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in12),
    .sel      (sel12),
    .in_valid (valid12),
    .out      (out12),
    .out_valid(ovalid12),
    .sel_err  (err12)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    in16    = 16'h5555;
    sel16   = 4'd0;
    valid16 = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out16 !== 1'b0 || ovalid16 !== 1'b0 || err16 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d: out=%b valid=%b err=%b, want 0/0/0", i, out16, ovalid16, err16);
      end
      step();
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (out16 !== 1'b1 || ovalid16 !== 1'b1 || err16 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: out=%b valid=%b err=%b, want 1/1/0", out16, ovalid16, err16);
    end
  endtask

  task automatic test_sweep();
    in16    = 16'h5555;
    valid16 = 1'b1;
    for (int s = 0; s < 16; s++) begin
      sel16 = 4'(s);
      step();
      n_checks++;
      if (out16 !== ((s % 2) == 0) || ovalid16 !== 1'b1 || err16 !== 1'b0) begin
        n_fail++;
        $display("FAIL sweep sel=%0d: out=%b valid=%b err=%b, want %b/1/0", s, out16, ovalid16, err16, (s % 2) == 0);
      end
    end
  endtask

  task automatic test_onehot();
    valid16 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in16  = 16'h0001 << k;
      sel16 = 4'(k);
      step();
      n_checks++;
      if (out16 !== 1'b1) begin
        n_fail++;
        $display("FAIL onehot_hit k=%0d: out=%b, want 1", k, out16);
      end
      sel16 = 4'((k + 1) % 16);
      step();
      n_checks++;
      if (out16 !== 1'b0) begin
        n_fail++;
        $display("FAIL onehot_miss k=%0d: out=%b, want 0", k, out16);
      end
    end
  endtask

  task automatic test_valid_gating();
    in16    = 16'hFFFF;
    sel16   = 4'd3;
    valid16 = 1'b1;
    step();
    n_checks++;
    if (out16 !== 1'b1 || ovalid16 !== 1'b1) begin
      n_fail++;
      $display("FAIL gate_setup: out=%b valid=%b, want 1/1", out16, ovalid16);
    end
    valid16 = 1'b0;
    in16    = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (out16 !== 1'b1 || ovalid16 !== 1'b0 || err16 !== 1'b0) begin
        n_fail++;
        $display("FAIL gate_hold cyc=%0d: out=%b valid=%b err=%b, want 1/0/0", i, out16, ovalid16, err16);
      end
    end
  endtask

  task automatic test_async_reset();
    in16    = 16'hFFFF;
    sel16   = 4'd5;
    valid16 = 1'b1;
    step();
    n_checks++;
    if (out16 !== 1'b1 || ovalid16 !== 1'b1) begin
      n_fail++;
      $display("FAIL async_setup: out=%b valid=%b, want 1/1", out16, ovalid16);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out16 !== 1'b0 || ovalid16 !== 1'b0 || err16 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: out=%b valid=%b err=%b, want 0/0/0", out16, ovalid16, err16);
    end
    #1 rst_n = 1'b1;
    in16 = 16'h5555;
    for (int s = 0; s < 4; s++) begin
      sel16 = 4'(s);
      step();
      n_checks++;
      if (out16 !== ((s % 2) == 0) || ovalid16 !== 1'b1) begin
        n_fail++;
        $display("FAIL async_resume sel=%0d: out=%b valid=%b, want %b/1", s, out16, ovalid16, (s % 2) == 0);
      end
    end
    valid16 = 1'b0;
  endtask

  task automatic test_out_of_range();
    logic [3:0] sel_v [6];
    logic       out_v [6];
    logic       err_v [6];
    sel_v = '{4'd13, 4'd11, 4'd12, 4'd0, 4'd15, 4'd7};
    out_v = '{1'b0,  1'b1,  1'b0,  1'b1, 1'b0,  1'b1};
    err_v = '{1'b1,  1'b0,  1'b1,  1'b0, 1'b1,  1'b0};
    in12    = 12'hFFF;
    valid12 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sel12 = sel_v[i];
      step();
      n_checks++;
      if (out12 !== out_v[i] || err12 !== err_v[i] || ovalid12 !== 1'b1) begin
        n_fail++;
        $display("FAIL oor sel=%0d: out=%b err=%b valid=%b, want %b/%b/1", sel_v[i], out12, err12, ovalid12, out_v[i], err_v[i]);
      end
    end
    valid12 = 1'b0;
    step();
    n_checks++;
    if (err12 !== 1'b0 || ovalid12 !== 1'b0 || out12 !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_idle: out=%b err=%b valid=%b, want 1/0/0", out12, err12, ovalid12);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    in12     = '0;
    sel12    = '0;
    valid12  = 1'b0;
    test_reset();
    test_sweep();
    test_onehot();
    test_valid_gating();
    test_async_reset();
    test_out_of_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
